// File: rtl/rfsoc_simple_blck_wrapper.sv
// PL top of the simple RFSoC system: PS register file packs {timestamp, data} entries
// into a FIFO, and the RTO engine releases each entry when the free-running counter hits its timestamp.
module rfsoc_simple_blck_wrapper #(
    parameter int FIFO_DEPTH = 16,
    parameter int TS_W       = 64,
    parameter int DATA_W     = 64
) (
    input  logic                     pl_clk0,
    input  logic                     pl_resetn0,
    input  logic                     reg_wr_en,
    input  logic                     reg_rd_en,
    input  logic [2:0]               reg_addr,
    input  logic [63:0]              reg_wdata,
    output logic [63:0]              reg_rdata,
    output logic [TS_W+DATA_W-1:0]   fifo_din,
    output logic                     fifo_wr_en,
    output logic [DATA_W-1:0]        rto_data,
    output logic                     rto_valid,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW = TS_W + DATA_W;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    localparam logic [2:0] A_TS     = 3'd0;
    localparam logic [2:0] A_DATA   = 3'd1;
    localparam logic [2:0] A_PUSH   = 3'd2;
    localparam logic [2:0] A_CTRL   = 3'd3;
    localparam logic [2:0] A_STATUS = 3'd4;
    localparam logic [2:0] A_CNT    = 3'd5;

    logic [TS_W-1:0]   ts_q, cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, rto_data_q;
    logic              en_q, ovf_q, unf_q, rto_valid_q;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       fill_q, fill_d;
    logic [63:0]       rdata_q, rdata_d;
    logic [EW-1:0]     mem_q [FIFO_DEPTH];

    logic              wr_ctrl, cnt_clr, flag_clr, push_req, push_ok, ovf_set;
    logic              empty, full, due, rel, late, pop;
    logic [EW-1:0]     head;
    logic [TS_W-1:0]   head_ts;
    logic [DATA_W-1:0] head_data;
    logic [8:0]        fill9;

    assign wr_ctrl  = reg_wr_en && (reg_addr == A_CTRL);
    assign cnt_clr  = wr_ctrl && reg_wdata[1];
    assign flag_clr = wr_ctrl && reg_wdata[2];
    assign push_req = reg_wr_en && (reg_addr == A_PUSH);

    assign empty     = (fill_q == '0);
    assign full      = (fill_q == FULL_CNT);
    assign head      = mem_q[rd_ptr_q];
    assign head_ts   = head[EW-1:DATA_W];
    assign head_data = head[DATA_W-1:0];

    // Compare against the pre-increment counter; a late head is dropped without output.
    assign due  = !empty && en_q;
    assign rel  = due && (head_ts == cnt_q);
    assign late = due && (head_ts < cnt_q);
    assign pop  = rel || late;

    // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
    assign push_ok = push_req && (!full || pop);
    assign ovf_set = push_req && full && !pop;

    always_comb begin
        fill_d = fill_q;
        case ({push_ok, pop})
            2'b10:   fill_d = fill_q + (AW+1)'(1);
            2'b01:   fill_d = fill_q - (AW+1)'(1);
            default: fill_d = fill_q;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr)   cnt_d = '0;
        else if (en_q) cnt_d = cnt_q + TS_W'(1);
    end

    assign fill9 = 9'(fill_q);

    always_comb begin
        rdata_d = '0;
        case (reg_addr)
            A_TS:     rdata_d = 64'(ts_q);
            A_DATA:   rdata_d = 64'(data_q);
            A_CTRL:   rdata_d = {63'd0, en_q};
            A_STATUS: rdata_d = {48'd0, fill9[7:0], 4'd0, ovf_q, unf_q, full, empty};
            A_CNT:    rdata_d = 64'(cnt_q);
            default:  rdata_d = '0;
        endcase
    end

    always_ff @(posedge pl_clk0 or negedge pl_resetn0) begin
        if (!pl_resetn0) begin
            ts_q        <= '0;
            data_q      <= '0;
            en_q        <= 1'b0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            rdata_q     <= '0;
            rto_data_q  <= '0;
            rto_valid_q <= 1'b0;
        end else begin
            if (reg_wr_en && reg_addr == A_TS)   ts_q   <= TS_W'(reg_wdata);
            if (reg_wr_en && reg_addr == A_DATA) data_q <= DATA_W'(reg_wdata);
            if (wr_ctrl)                         en_q   <= reg_wdata[0];
            if (reg_rd_en)                       rdata_q <= rdata_d;
            cnt_q  <= cnt_d;
            fill_q <= fill_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            ovf_q <= ovf_set || (ovf_q && !flag_clr);
            unf_q <= late    || (unf_q && !flag_clr);
            rto_valid_q <= rel;
            if (rel) rto_data_q <= head_data;
        end
    end

    // Storage needs no reset: entries past the pointers are never observed.
    always_ff @(posedge pl_clk0) begin
        if (push_ok) mem_q[wr_ptr_q] <= {ts_q, data_q};
    end

    assign reg_rdata  = rdata_q;
    assign fifo_din   = {ts_q, data_q};
    assign fifo_wr_en = push_req;
    assign rto_data   = rto_data_q;
    assign rto_valid  = rto_valid_q;
    assign fifo_full  = full;
    assign fifo_empty = empty;
    assign overflow   = ovf_q;
    assign underflow  = unf_q;
endmodule

// File: tb/tb_rfsoc_simple_blck_wrapper.sv
// Bench for rfsoc_simple_blck_wrapper: directed scenarios plus a randomized run,
// all checked against a queue-based model of the register map, FIFO and RTO rules.
module tb_rfsoc_simple_blck_wrapper;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         reg_wr_en = 1'b0, reg_rd_en = 1'b0;
    logic [2:0]   reg_addr = '0;
    logic [63:0]  reg_wdata = '0;
    logic [63:0]  reg_rdata;
    logic [127:0] fifo_din;
    logic         fifo_wr_en;
    logic [63:0]  rto_data;
    logic         rto_valid, fifo_full, fifo_empty, overflow, underflow;

    rfsoc_simple_blck_wrapper #(.FIFO_DEPTH(16), .TS_W(64), .DATA_W(64)) dut (
        .pl_clk0(clk), .pl_resetn0(rst_n),
        .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en),
        .rto_data(rto_data), .rto_valid(rto_valid),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: queue of {ts, data} entries plus architectural registers.
    logic [63:0]  m_ts, m_data, m_cnt, m_rdata, m_rto_data;
    bit           m_en, m_ovf, m_unf, m_rto_valid;
    logic [127:0] q[$];

    task automatic m_reset();
        m_ts = 0; m_data = 0; m_cnt = 0; m_rdata = 0; m_rto_data = 0;
        m_en = 0; m_ovf = 0; m_unf = 0; m_rto_valid = 0;
        q.delete();
    endtask

    function automatic logic [63:0] m_read(input logic [2:0] a);
        logic [63:0] v = 0;
        case (a)
            3'd0: v = m_ts;
            3'd1: v = m_data;
            3'd3: v = {63'd0, m_en};
            3'd4: v = (64'(q.size()) << 8) | {60'd0, m_ovf, m_unf, q.size() == 16, q.size() == 0};
            3'd5: v = m_cnt;
            default: v = 0;
        endcase
        return v;
    endfunction

    task automatic m_step(input bit wr, input bit rd, input logic [2:0] a, input logic [63:0] wd);
        logic [127:0] h = 0;
        bit rel = 0, late = 0;
        bit ctrl = wr && (a == 3'd3);
        if (rd) m_rdata = m_read(a);
        if (q.size() > 0 && m_en) begin
            h = q[0];
            if (h[127:64] == m_cnt)     rel = 1;
            else if (h[127:64] < m_cnt) late = 1;
        end
        if (ctrl && wd[2]) begin m_ovf = 0; m_unf = 0; end
        if (rel || late) void'(q.pop_front());
        if (late) m_unf = 1;
        if (wr && a == 3'd2) begin
            if (q.size() < 16) q.push_back({m_ts, m_data});
            else m_ovf = 1;
        end
        m_rto_valid = rel;
        if (rel) m_rto_data = h[63:0];
        if (ctrl && wd[1]) m_cnt = 0;
        else if (m_en)     m_cnt = m_cnt + 1;
        if (ctrl)              m_en = wd[0];
        if (wr && a == 3'd0)   m_ts = wd;
        if (wr && a == 3'd1)   m_data = wd;
    endtask

    task automatic check_outs();
        chk("rto_valid", rto_valid, m_rto_valid);
        chk("rto_data", rto_data, m_rto_data);
        chk("empty", fifo_empty, q.size() == 0);
        chk("full", fifo_full, q.size() == 16);
        chk("overflow", overflow, m_ovf);
        chk("underflow", underflow, m_unf);
        chk("rdata", reg_rdata, m_rdata);
        chk("fifo_din", fifo_din, {m_ts, m_data});
    endtask

    // One clock: drive at edge+1, check the combinational push strobe, then outputs after the edge.
    task automatic step(input bit wr, input bit rd, input logic [2:0] a, input logic [63:0] wd);
        reg_wr_en = wr; reg_rd_en = rd; reg_addr = a; reg_wdata = wd;
        #1;
        chk("fifo_wr_en", fifo_wr_en, wr && a == 3'd2);
        @(posedge clk);
        m_step(wr, rd, a, wd);
        #1;
        check_outs();
        reg_wr_en = 0; reg_rd_en = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 3'd0, 64'd0);
    endtask

    task automatic push(input logic [63:0] ts, input logic [63:0] d);
        step(1, 0, 3'd0, ts);
        step(1, 0, 3'd1, d);
        step(1, 0, 3'd2, 64'd0);
    endtask

    task automatic do_reset();
        reg_wr_en = 0; reg_rd_en = 0;
        rst_n = 0;
        m_reset();
        #1;
        check_outs();
        repeat (20) @(posedge clk);
        #1;
        check_outs();
        rst_n = 1;
    endtask

    int pulses, j, k;
    logic [63:0] exp_cnt [2];
    logic [63:0] ts, d;
    int r;

    initial begin
        m_reset();
        @(posedge clk); #1;
        do_reset();

        // Reset mid-stream with the counter running.
        push(64'd500, 64'h11);
        push(64'd600, 64'h22);
        step(1, 0, 3'd3, 64'd1);
        idle(10);
        do_reset();
        step(0, 1, 3'd5, 64'd0);
        chk("cnt_after_rst", reg_rdata, 64'd0);

        // Packing and single push.
        step(1, 0, 3'd0, 64'h0000_0000_0000_0100);
        step(1, 0, 3'd1, 64'hDEAD_BEEF_CAFE_F00D);
        chk("din_pack", fifo_din, 128'h0000000000000100DEADBEEFCAFEF00D);
        step(1, 0, 3'd2, 64'd0);
        step(0, 1, 3'd4, 64'd0);
        chk("fill_one", reg_rdata[15:8], 8'd1);

        // Timed release: pulses must land when the counter reads 21 and 26.
        do_reset();
        push(64'd20, 64'hA0A0);
        push(64'd25, 64'hB1B1);
        step(1, 0, 3'd3, 64'd1);
        exp_cnt[0] = 64'd21; exp_cnt[1] = 64'd26;
        pulses = 0;
        for (j = 1; j <= 40; j++) begin
            step(0, 0, 3'd0, 64'd0);
            if (rto_valid) begin
                if (pulses < 2) chk("rel_cnt", 64'(j), exp_cnt[pulses]);
                chk("rel_data", rto_data, pulses == 0 ? 64'hA0A0 : 64'hB1B1);
                pulses++;
            end
        end
        chk("rel_pulses", pulses, 2);
        chk("rel_empty", fifo_empty, 1'b1);

        // Late entry.
        do_reset();
        step(1, 0, 3'd3, 64'd1);
        idle(100);
        pulses = 0;
        push(64'd50, 64'h5050);
        for (k = 0; k < 3; k++) begin
            step(0, 0, 3'd0, 64'd0);
            if (rto_valid) pulses++;
        end
        chk("late_unf", underflow, 1'b1);
        chk("late_nopulse", pulses, 0);
        chk("late_empty", fifo_empty, 1'b1);
        step(1, 0, 3'd3, 64'd5);
        chk("late_clr", underflow, 1'b0);

        // Overflow: 17 pushes into 16 slots; the 17th must never come out.
        do_reset();
        for (k = 0; k < 17; k++) push(64'(10 + k), 64'(100 + k));
        chk("ovf_full", fifo_full, 1'b1);
        chk("ovf_flag", overflow, 1'b1);
        step(0, 1, 3'd4, 64'd0);
        chk("ovf_fill", reg_rdata[15:8], 8'd16);
        step(1, 0, 3'd3, 64'd1);
        pulses = 0;
        for (k = 0; k < 40; k++) begin
            step(0, 0, 3'd0, 64'd0);
            if (rto_valid) pulses++;
        end
        chk("ovf_pulses", pulses, 16);
        chk("ovf_last", rto_data, 64'd115);

        // Push into a full FIFO in the same cycle as a due pop.
        do_reset();
        push(64'd0, 64'h55);
        for (k = 1; k < 16; k++) push(64'(50 + k), 64'(k));
        step(1, 0, 3'd0, 64'd99);
        step(1, 0, 3'd3, 64'd1);
        step(1, 0, 3'd2, 64'd0);
        chk("sim_ovf", overflow, 1'b0);
        chk("sim_full", fifo_full, 1'b1);
        chk("sim_rel", rto_valid, 1'b1);
        step(0, 1, 3'd4, 64'd0);
        chk("sim_fill", reg_rdata[15:8], 8'd16);

        // Randomized traffic against the model.
        do_reset();
        step(1, 0, 3'd3, 64'd1);
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 20) begin
                ts = m_cnt + 64'($urandom_range(2, 40));
                if ($urandom_range(0, 4) == 0 && m_cnt > 64'd10) ts = m_cnt - 64'($urandom_range(1, 10));
                if ($urandom_range(0, 5) == 0 && q.size() > 0) begin
                    d = q[q.size()-1];
                    ts = d[127:64];
                end
                step(1, $urandom_range(0, 1), 3'($urandom_range(0, 7)), ts);
                reg_addr = 3'd0;
            end else if (r < 35) begin
                step(1, 0, 3'd1, {$urandom, $urandom});
            end else if (r < 55) begin
                step(1, $urandom_range(0, 1), 3'd2, 64'd0);
            end else if (r < 60) begin
                d = 64'({($urandom_range(0, 3) == 0), ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) != 0)});
                step(1, 0, 3'd3, d);
            end else if (r < 78) begin
                step(0, 1, 3'($urandom_range(0, 7)), 64'd0);
            end else if (r < 80) begin
                step(1, 0, 3'($urandom_range(6, 7)), {$urandom, $urandom});
            end else begin
                step(0, 0, 3'd0, 64'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
